serial_parity_transmitter: RTL
==============================

SERIAL_PARITY_TRANSMITTER -- requirements
Module: serial_parity_transmitter

Interface
REQ-001 The module SHALL have parameter DATA_BITS, default 8, giving the payload width in bits; legal range is 2..16.
REQ-002 The module SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The module SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 The module SHALL have port start, input, 1 bit: request to transmit data_in, sampled on the rising edge of clk.
REQ-005 The module SHALL have port data_in, input, DATA_BITS bits: payload, captured only on an accepted start.
REQ-006 The module SHALL have port serial_out, output, 1 bit: serial line carrying payload bits, then one even-parity bit.
REQ-007 The module SHALL have port serial_valid, output, 1 bit: high in every cycle in which serial_out carries a frame bit.
REQ-008 The module SHALL have port busy, output, 1 bit: high while a frame is in progress, meaning state is not IDLE.
REQ-009 The module SHALL have port done, output, 1 bit: one-cycle pulse that is high during the parity-bit cycle.

Function
REQ-010 The module SHALL implement an FSM with exactly three states: IDLE, DATA and PARITY.
REQ-011 In IDLE with start=1, the module SHALL, at the next edge: latch data_in into a shift register, clear the bit counter, clear the running parity, and enter DATA.
REQ-012 In IDLE with start=0, the module SHALL remain in IDLE with serial_out=0, serial_valid=0, busy=0 and done=0.
REQ-013 In DATA, the module SHALL drive one payload bit per cycle, LSB first, with serial_valid=1 and busy=1.
REQ-014 Payload bit i (i = 0..DATA_BITS-1) SHALL appear in the i-th cycle after the start edge.
REQ-015 On each DATA cycle, the module SHALL XOR the transmitted bit into the running parity register.
REQ-016 The module SHALL leave DATA for PARITY after exactly DATA_BITS cycles, when the counter reaches DATA_BITS-1.
REQ-017 In PARITY, for exactly one cycle, the module SHALL drive serial_out = XOR of all payload bits, so that the total count of 1s in the frame is even, with serial_valid=1, busy=1 and done=1.
REQ-018 From PARITY, the module SHALL return to IDLE if start=0.
REQ-019 From PARITY with start=1, the module SHALL accept the new data_in and enter DATA directly, giving back-to-back frames with no gap cycle.
REQ-020 Start latency SHALL be 1 cycle from the start edge to the first payload bit.
REQ-021 Frame length SHALL be DATA_BITS+1 cycles.
REQ-022 The module SHALL ignore start while in DATA, and SHALL ignore data_in changes after capture.
REQ-023 All outputs SHALL be registered or decoded purely from registered state; there SHALL be no combinational path from start or data_in to any output.
REQ-024 The bit counter SHALL be ceil(log2(DATA_BITS)) bits wide and SHALL NOT wrap beyond DATA_BITS-1.
REQ-025 The serial stream, fed bit-serially into an even-parity checker that was reset before the frame, SHALL leave that checker in its even state after every complete frame.

Reset
REQ-026 While reset=1 at a clock edge, the module SHALL enter IDLE and clear the shift register, the counter and the running parity.
REQ-027 While reset=1 at a clock edge, the module SHALL force serial_out=0, serial_valid=0, busy=0 and done=0.
REQ-028 Reset SHALL take priority over start.
REQ-029 A reset asserted mid-frame SHALL abort the frame immediately, with no parity bit emitted.
REQ-030 After reset deasserts, the module SHALL accept a new start on the first following edge.

Verification
REQ-031 Basic frame: DATA_BITS=8, start pulse with data_in=8'hA5 -> serial_out 1,0,1,0,0,1,0,1 on cycles 1..8, then parity 0 on cycle 9 with done=1, then IDLE.
REQ-032 Odd payload: data_in=8'h07 -> bits 1,1,1,0,0,0,0,0, then parity 1; an attached even-parity checker reads even (error output 0) after the frame.
REQ-033 Back-to-back frames: start held high with 8'hFF then 8'h01 -> second frame's first bit (1) directly follows the first frame's parity bit (0); the second frame's parity is 1; busy stays high for 18 cycles.
REQ-034 Start during busy: assert start with 8'h00 in cycle 3 of an 8'hA5 frame -> no effect; the 8'hA5 frame completes unchanged.
REQ-035 Reset mid-frame: reset=1 in cycle 4 of an 8'hFF frame -> the next cycle shows busy=0, serial_valid=0, serial_out=0 and no done pulse; a new start with 8'h03 then sends 1,1,0,0,0,0,0,0 followed by parity 0.
REQ-036 Reset priority: reset=1 and start=1 on the same edge -> the module remains IDLE with all outputs 0.

Source files
------------

// File: rtl/serial_parity_transmitter_if.sv
// serial_parity_transmitter_if: start/payload request and serial frame outputs
interface serial_parity_transmitter_if #(parameter int DATA_BITS = 8);
    logic start;
    logic [DATA_BITS-1:0] data_in;
    logic serial_out;
    logic serial_valid;
    logic busy;
    logic done;
    modport master(output start, data_in, input serial_out, serial_valid, busy, done);
    modport slave(input start, data_in, output serial_out, serial_valid, busy, done);
endinterface

// File: rtl/serial_parity_transmitter.sv
// serial_parity_transmitter: LSB-first payload shifter followed by one even-parity bit
module serial_parity_transmitter #(
    parameter int DATA_BITS = 8
) (
    input logic clk,
    input logic reset,
    serial_parity_transmitter_if.slave bus
);
    localparam int CW = $clog2(DATA_BITS);
    typedef enum logic [1:0] {IDLE, DATA, PARITY} state_t;
    state_t state, state_next;
    logic [DATA_BITS-1:0] shreg;
    logic [CW-1:0] cnt;
    logic par;
    logic last;
    logic load;
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else state <= state_next;
    end
    // start is honoured in IDLE and in PARITY, the latter giving gapless back-to-back frames
    always_comb begin
        last = cnt == CW'(DATA_BITS - 1);
        load = bus.start && (state == IDLE || state == PARITY);
        state_next = load ? DATA : (state == DATA) ? (last ? PARITY : DATA) : IDLE;
        bus.serial_out = (state == DATA) ? shreg[0] : (state == PARITY) ? par : 1'b0;
        bus.serial_valid = state == DATA || state == PARITY;
        bus.busy = state == DATA || state == PARITY;
        bus.done = state == PARITY;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            shreg <= '0;
            cnt <= '0;
            par <= 1'b0;
        end else if (load) begin
            shreg <= bus.data_in;
            cnt <= '0;
            par <= 1'b0;
        end else if (state == DATA) begin
            shreg <= {1'b0, shreg[DATA_BITS-1:1]};
            cnt <= last ? cnt : cnt + 1'b1;
            par <= par ^ shreg[0];
        end
    end
endmodule
